digit_counter: RTL and testbench

DIGIT_COUNTER -- requirements
Module: digit_counter

---
 rtl/digit_counter.sv | 158 +++++++++++++++
 tb/tb_digit_counter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_counter.sv
// Single-digit up/down counter with start/pause/clear control feeding a 7-segment encoder.
// Define DIGIT_COUNTER_BLINK_EN to blink the display while paused.
module digit_counter #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] out,
    output logic       enable,
    output logic       tc
);

    localparam int unsigned   PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_t;

    state_t          r_state;
    logic            r_start_prev;
    logic            r_stop_prev;
    logic [PW-1:0]   r_presc;
    logic [3:0]      r_out;
    logic            r_enable;
    logic            r_tc;

    state_t          w_state_nxt;
    logic [PW-1:0]   w_presc_nxt;
    logic [3:0]      w_out_nxt;
    logic            w_enable_nxt;
    logic            w_tc_nxt;

    logic            w_start_edge;
    logic            w_stop_edge;
    logic            w_presc_wrap;
    logic [3:0]      w_step_val;
    logic            w_step_wrap;

    assign w_start_edge = start & ~r_start_prev;
    assign w_stop_edge  = stop & ~r_stop_prev;
    assign w_presc_wrap = (r_presc == PRESC_MAX);
    assign w_step_val   = up ? (r_out + 4'd1) : (r_out - 4'd1);
    assign w_step_wrap  = up ? (r_out == 4'hF) : (r_out == 4'h0);

    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_out_nxt    = r_out;
        w_enable_nxt = r_enable;
        w_tc_nxt     = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_out_nxt    = 4'h0;
                w_enable_nxt = 1'b0;
                w_presc_nxt  = '0;
                // A coincident stop edge cancels the start request.
                if (w_start_edge && !w_stop_edge) begin
                    w_state_nxt  = StRun;
                    w_enable_nxt = 1'b1;
                end else if (load) begin
                    w_state_nxt  = StPause;
                    w_enable_nxt = 1'b1;
                end
                if (load) begin
                    w_out_nxt = load_val;
                end
            end

            StRun: begin
                w_enable_nxt = 1'b1;
                if (w_stop_edge) begin
                    w_state_nxt = StPause;
                end
                if (load) begin
                    w_out_nxt   = load_val;
                    w_presc_nxt = '0;
                end else if (w_presc_wrap) begin
                    w_out_nxt   = w_step_val;
                    w_tc_nxt    = w_step_wrap;
                    w_presc_nxt = '0;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end

            StPause: begin
                if (w_stop_edge) begin
                    // Clear wins over load and start in the same cycle.
                    w_state_nxt  = StIdle;
                    w_out_nxt    = 4'h0;
                    w_enable_nxt = 1'b0;
                end else begin
                    if (load) begin
                        w_out_nxt   = load_val;
                        w_presc_nxt = '0;
`ifdef DIGIT_COUNTER_BLINK_EN
                    end else if (w_presc_wrap) begin
                        w_presc_nxt  = '0;
                        w_enable_nxt = ~r_enable;
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
`else
                    end else begin
                        w_presc_nxt = '0;
                    end
                    w_enable_nxt = 1'b1;
`endif
                    if (w_start_edge) begin
                        w_state_nxt  = StRun;
                        w_enable_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt  = StIdle;
                w_out_nxt    = 4'h0;
                w_enable_nxt = 1'b0;
            end
        endcase

        // Every state change restarts the step/blink timebase.
        if (w_state_nxt != r_state) begin
            w_presc_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
            r_presc      <= '0;
            r_out        <= 4'h0;
            r_enable     <= 1'b0;
            r_tc         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_prev <= start;
            r_stop_prev  <= stop;
            r_presc      <= w_presc_nxt;
            r_out        <= w_out_nxt;
            r_enable     <= w_enable_nxt;
            r_tc         <= w_tc_nxt;
        end
    end

    assign out    = r_out;
    assign enable = r_enable;
    assign tc     = r_tc;

endmodule

// File: tb/tb_digit_counter.sv
// Scoreboard bench for digit_counter at TICK_DIV=4; expected {out,enable,tc} queued per driven cycle.
module tb_digit_counter;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] out;
    logic       enable;
    logic       tc;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] exp_q[$];

    typedef struct packed {
        logic       rst;
        logic       st;
        logic       sp;
        logic       ld;
        logic [3:0] lv;
        logic [5:0] exp;
    } vec_t;

    digit_counter #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .enable   (enable),
        .tc       (tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got, want;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) reset = 1'b0;
            exp_q.push_back(6'b0000_0_0);
            tick();
            got  = {out, enable, tc};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset[%0d]: out/en/tc = %h/%b/%b, expected %h/%b/%b",
                         i, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_count_up();
        logic [5:0] got, want;
        up    = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({4'(i / 4), 1'b1, 1'b0});
            tick();
            start = 1'b0;
            got  = {out, enable, tc};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL count_up[%0d]: out/en/tc = %h/%b/%b, expected %h/%b/%b",
                         i, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
            end
        end
    endtask

    // Load lands on a step cycle, so the step must be suppressed.
    task automatic test_load_wrap_up();
        logic [5:0] got, want;
        load     = 1'b1;
        load_val = 4'hE;
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back({4'(14 + i / 4), 1'b1, (i == 8)});
            tick();
            load = 1'b0;
            got  = {out, enable, tc};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL load_wrap_up[%0d]: out/en/tc = %h/%b/%b, expected %h/%b/%b",
                         i, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_wrap_down();
        logic [5:0] got, want;
        up       = 1'b0;
        load     = 1'b1;
        load_val = 4'h0;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({4'(16 - i / 4), 1'b1, (i == 4)});
            tick();
            load = 1'b0;
            got  = {out, enable, tc};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL wrap_down[%0d]: out/en/tc = %h/%b/%b, expected %h/%b/%b",
                         i, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_pause_clear();
        logic [5:0] got, want;
        logic       en_exp;
        stop = 1'b1;
        for (int i = 0; i < 16; i++) begin
`ifdef DIGIT_COUNTER_BLINK_EN
            en_exp = ((i / 4) % 2 == 0);
`else
            en_exp = 1'b1;
`endif
            if (i < 12) exp_q.push_back({4'hE, en_exp, 1'b0});
            else        exp_q.push_back(6'b0000_0_0);
            // Second stop edge with a load that must be ignored.
            if (i == 12) begin
                stop     = 1'b1;
                load     = 1'b1;
                load_val = 4'h5;
            end
            tick();
            stop = 1'b0;
            load = 1'b0;
            got  = {out, enable, tc};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL pause_clear[%0d]: out/en/tc = %h/%b/%b, expected %h/%b/%b",
                         i, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_coincident();
        logic [5:0] got, want;
        vec_t       tbl[13];
        up = 1'b1;
        tbl[0]  = {1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 4'h3, 1'b1, 1'b0};
        tbl[1]  = {1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[2]  = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[3]  = {1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0};
        tbl[4]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};
        tbl[5]  = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};
        tbl[6]  = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};
        tbl[7]  = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};
        tbl[8]  = {1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 4'h9, 1'b1, 1'b0};
        tbl[9]  = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 1'b1, 1'b0};
        tbl[10] = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 1'b1, 1'b0};
        tbl[11] = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 1'b1, 1'b0};
        tbl[12] = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hA, 1'b1, 1'b0};
        for (int i = 0; i < 13; i++) begin
            reset    = tbl[i].rst;
            start    = tbl[i].st;
            stop     = tbl[i].sp;
            load     = tbl[i].ld;
            load_val = tbl[i].lv;
            exp_q.push_back(tbl[i].exp);
            tick();
            got  = {out, enable, tc};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL coincident[%0d]: out/en/tc = %h/%b/%b, expected %h/%b/%b",
                         i, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [5:0] got, want;
        vec_t       tbl[9];
        tbl[0] = {1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 4'h7, 1'b1, 1'b0};
        tbl[1] = {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b1, 1'b0};
        tbl[2] = {1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0};
        tbl[3] = {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[4] = {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0};
        tbl[5] = {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0};
        tbl[6] = {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0};
        tbl[7] = {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0};
        tbl[8] = {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            reset    = tbl[i].rst;
            start    = tbl[i].st;
            stop     = tbl[i].sp;
            load     = tbl[i].ld;
            load_val = tbl[i].lv;
            exp_q.push_back(tbl[i].exp);
            tick();
            got  = {out, enable, tc};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_mid_run[%0d]: out/en/tc = %h/%b/%b, expected %h/%b/%b",
                         i, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
            end
        end
        start = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 4'h0;

        test_reset();
        test_count_up();
        test_load_wrap_up();
        test_wrap_down();
        test_pause_clear();
        test_coincident();
        test_reset_mid_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
